// File: rtl/red_16_bit_pkg.sv
// red_16_bit_pkg
// Shared constants for the WISC-F24 reduction (RED) unit: operand, byte and
// reduction-result widths, the RED opcode, and the sign-extension helper used
// to widen the 10-bit reduction result onto the 16-bit datapath.
package red_16_bit_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned RED_W  = 10;

  // ALU opcode that selects the RED result
  localparam logic [3:0] OPC_RED = 4'b0011;

  // Sign-extend the reduction result from its top bit to the datapath width
  function automatic logic [DATA_W-1:0] sign_ext_red(input logic [RED_W-1:0] red);
    return {{(DATA_W - RED_W){red[RED_W-1]}}, red};
  endfunction

endpackage

// File: rtl/red_16_bit_cla_4bit.sv
// cla_4bit
// 4-bit carry-lookahead adder slice. Slices are chained through cin/cout to
// build the wider adders of the reduction tree.
// Ports:
//   a, b : 4-bit addends
//   cin  : carry in
//   s    : 4-bit sum
//   cout : carry out
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  // Generate/propagate terms and flattened lookahead carries
  always_comb begin
    g_s    = a & b;
    p_s    = a ^ b;
    c_s[0] = cin;
    c_s[1] = g_s[0] | (p_s[0] & cin);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & cin);
    c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
    s      = p_s ^ c_s[3:0];
    cout   = c_s[4];
  end

endmodule

// File: rtl/red_16_bit.sv
// red_16_bit
// Reduction unit of the WISC-F24 ALU: adds the high bytes and the low bytes of
// the two operands, adds those two 9-bit sums, sign-extends the 10-bit result
// from bit 9 and registers it with one cycle of latency.
// Optional feature macro: RED_16BIT_FLAGS_EN adds registered flag_n/flag_z.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (priority over valid_in)
//   valid_in  : operands valid this cycle
//   a_in      : operand rs
//   b_in      : operand rt
//   sum_out   : registered, sign-extended reduction result (holds when idle)
//   valid_out : sum_out was updated on the last edge
//   flag_n    : (RED_16BIT_FLAGS_EN) sign of sum_out
//   flag_z    : (RED_16BIT_FLAGS_EN) sum_out is zero
module red_16_bit
  import red_16_bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] sum_out,
  output logic              valid_out
`ifdef RED_16BIT_FLAGS_EN
  ,
  output logic              flag_n,
  output logic              flag_z
`endif
);

  logic [BYTE_W:0]     hi_sum_s;
  logic [BYTE_W:0]     lo_sum_s;
  logic                hi_c_s;
  logic                lo_c_s;
  logic [11:0]         red_a_s;
  logic [11:0]         red_b_s;
  logic [11:0]         red_full_s;
  logic [1:0]          red_c_s;
  logic                red_cout_s;
  logic [2:0]          red_unused_s;
  logic [RED_W-1:0]    red_s;
  logic [DATA_W-1:0]   sum_nxt_s;

  // High-byte adder: two chained slices, carry lands in bit 8
  cla_4bit u_hi_lo (.a(a_in[11:8]),  .b(b_in[11:8]),  .cin(1'b0),   .s(hi_sum_s[3:0]), .cout(hi_c_s));
  cla_4bit u_hi_hi (.a(a_in[15:12]), .b(b_in[15:12]), .cin(hi_c_s), .s(hi_sum_s[7:4]), .cout(hi_sum_s[8]));

  // Low-byte adder
  cla_4bit u_lo_lo (.a(a_in[3:0]), .b(b_in[3:0]), .cin(1'b0),   .s(lo_sum_s[3:0]), .cout(lo_c_s));
  cla_4bit u_lo_hi (.a(a_in[7:4]), .b(b_in[7:4]), .cin(lo_c_s), .s(lo_sum_s[7:4]), .cout(lo_sum_s[8]));

  // Zero-extend both 9-bit sums to the three-slice width of the second level
  assign red_a_s = {3'b000, hi_sum_s};
  assign red_b_s = {3'b000, lo_sum_s};

  // Second level: 10 meaningful bits out of three slices
  cla_4bit u_red_0 (.a(red_a_s[3:0]),  .b(red_b_s[3:0]),  .cin(1'b0),       .s(red_full_s[3:0]),  .cout(red_c_s[0]));
  cla_4bit u_red_1 (.a(red_a_s[7:4]),  .b(red_b_s[7:4]),  .cin(red_c_s[0]), .s(red_full_s[7:4]),  .cout(red_c_s[1]));
  cla_4bit u_red_2 (.a(red_a_s[11:8]), .b(red_b_s[11:8]), .cin(red_c_s[1]), .s(red_full_s[11:8]), .cout(red_cout_s));

  // Sum never exceeds 0x3FC, so the top two slice bits and carry are always zero
  assign red_unused_s = {red_cout_s, red_full_s[11:10]};
  assign red_s        = red_full_s[RED_W-1:0];
  assign sum_nxt_s    = sign_ext_red(red_s);

  // Output register: reset clears, valid_in captures, otherwise hold the result
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_out   <= 16'h0000;
      valid_out <= 1'b0;
`ifdef RED_16BIT_FLAGS_EN
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
`endif
    end else if (valid_in) begin
      sum_out   <= sum_nxt_s;
      valid_out <= 1'b1;
`ifdef RED_16BIT_FLAGS_EN
      flag_n    <= sum_nxt_s[DATA_W-1];
      flag_z    <= (sum_nxt_s == 16'h0000);
`endif
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_red_16_bit.sv
module tb_red_16_bit;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [15:0] sum_out;
  logic        valid_out;
`ifdef RED_16BIT_FLAGS_EN
  logic        flag_n;
  logic        flag_z;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] exp_sum;
  logic        exp_valid;
  logic        exp_n;
  logic        exp_z;

  red_16_bit dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .sum_out  (sum_out),
    .valid_out(valid_out)
`ifdef RED_16BIT_FLAGS_EN
    ,
    .flag_n   (flag_n),
    .flag_z   (flag_z)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: byte-wise sum, sign-extended from bit 9
  function automatic logic [15:0] ref_red(input logic [15:0] a, input logic [15:0] b);
    logic [9:0] r;
    r = 10'(a[15:8]) + 10'(b[15:8]) + 10'(a[7:0]) + 10'(b[7:0]);
    return {{6{r[9]}}, r};
  endfunction

  // One clock step: drive inputs, push the expected result, then check after the edge
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    rst = r; valid_in = v; a_in = a; b_in = b;
    if (!r && v) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      exp_sum = 16'h0000; exp_valid = 1'b0; exp_n = 1'b0; exp_z = 1'b0;
    end else if (v) begin
      exp_sum = exp_q.pop_front();
      exp_valid = 1'b1;
      exp_n = exp_sum[15];
      exp_z = (exp_sum == 16'h0000);
    end else begin
      exp_valid = 1'b0;
    end
    checks++;
    assert (sum_out === exp_sum) else begin
      errors++;
      $error("FAIL %s sum_out: observed %h expected %h", tag, sum_out, exp_sum);
    end
    checks++;
    assert (valid_out === exp_valid) else begin
      errors++;
      $error("FAIL %s valid_out: observed %b expected %b", tag, valid_out, exp_valid);
    end
`ifdef RED_16BIT_FLAGS_EN
    checks++;
    assert (flag_n === exp_n) else begin
      errors++;
      $error("FAIL %s flag_n: observed %b expected %b", tag, flag_n, exp_n);
    end
    checks++;
    assert (flag_z === exp_z) else begin
      errors++;
      $error("FAIL %s flag_z: observed %b expected %b", tag, flag_z, exp_z);
    end
`endif
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst = 1'b1; valid_in = 1'b0; a_in = 16'h0000; b_in = 16'h0000;
    exp_sum = 16'h0000; exp_valid = 1'b0; exp_n = 1'b0; exp_z = 1'b0;

    step("reset0", 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("reset_v", 1'b1, 1'b1, 16'h1234, 16'h5678, 16'h0000);
    step("basic", 1'b0, 1'b1, 16'h22BB, 16'h22BB, 16'h01BA);
    step("zero", 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    step("max", 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFC);
    step("bit9_set", 1'b0, 1'b1, 16'h8080, 16'h8080, 16'hFE00);
    step("bit9_clr", 1'b0, 1'b1, 16'h7F7F, 16'h8080, 16'h01FE);
    step("hold0", 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000);
    step("hold1", 1'b0, 1'b0, 16'h0102, 16'h0304, 16'h0000);
    step("carry_lo", 1'b0, 1'b1, 16'h00FF, 16'h0001, 16'h0100);
    step("carry_hi", 1'b0, 1'b1, 16'hFF00, 16'h0100, 16'h0100);
    step("mix", 1'b0, 1'b1, 16'h1234, 16'h5678, 16'h0114);
    step("rst_mid", 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000);
    step("resume", 1'b0, 1'b1, 16'h8080, 16'h8080, 16'hFE00);
    step("idle", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      step("random", 1'b0, ($urandom_range(0, 3) != 0), ra, rb, ref_red(ra, rb));
    end
    step("final_zero", 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
